// File: rtl/noc_request_scheduler.sv
// ---------------------------------------------------------------------------
// noc_request_scheduler
//   Upstream feeder for the 2x2 mesh. Keeps one request FIFO per processor
//   (entries hold {len[7:0], dest[1:0]}) and runs one independent FSM per
//   source that drives that processor's 11-bit configure word
//   {len, dest, req}. Issue is paced on processor_ready[n], so each source
//   has at most one transaction in flight.
//
// Parameters
//   DEPTH        entries per FIFO (power of 2, >= 2)
//   ACK_TIMEOUT  cycles to wait for processor_ready to fall before re-pulsing
//
// Ports
//   clock            in   1   rising-edge clock
//   reset            in   1   asynchronous active-low reset
//   push_valid       in   1   enqueue request this cycle
//   push_src         in   2   source processor / FIFO select
//   push_dst         in   2   destination processor
//   push_len         in   8   burst length (0 is rejected)
//   push_ready       out  1   FIFO[push_src] can take a push this cycle
//   processor_ready  in   4   mesh ready, bit n = Pn
//   p0..p3_configure out  11  {len, dest, req} to mesh Pn
//   busy             out  4   source n has a transaction in flight
//   fifo_empty       out  4   FIFO n empty (registered, exact)
//   err_zero_len     out  1   1-cycle pulse: a zero-length push was dropped
//
// Optional feature (macro NOC_SCHED_STATS_EN)
//   Adds output done_count[63:0]: 16-bit saturating completion counter per
//   source, [16n+15:16n] for Pn, bumped on every WAIT_DONE -> IDLE.
// ---------------------------------------------------------------------------
module noc_request_scheduler #(
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        push_valid,
  input  logic [1:0]  push_src,
  input  logic [1:0]  push_dst,
  input  logic [7:0]  push_len,
  output logic        push_ready,
  input  logic [3:0]  processor_ready,
  output logic [10:0] p0_configure,
  output logic [10:0] p1_configure,
  output logic [10:0] p2_configure,
  output logic [10:0] p3_configure,
  output logic [3:0]  busy,
  output logic [3:0]  fifo_empty,
  output logic        err_zero_len
`ifdef NOC_SCHED_STATS_EN
  ,
  output logic [63:0] done_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_ACK  = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  logic [3:0]  w_full;
  logic [3:0]  w_pop;
  logic        w_push_ok;
  logic [10:0] w_cfg [4];
  logic        r_err_zero_len;

  // A full FIFO still takes a push on the edge its head is popped.
  assign push_ready = !w_full[push_src] || w_pop[push_src];
  assign w_push_ok  = push_valid && push_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_err_zero_len <= 1'b0;
    else        r_err_zero_len <= w_push_ok && (push_len == 8'd0);
  end

  assign err_zero_len = r_err_zero_len;

  for (genvar n = 0; n < 4; n++) begin : g_src
    logic [9:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic          r_empty;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [TW-1:0] r_timer;
    logic [7:0]    r_len;
    logic [1:0]    r_dst;
    logic          w_wr_en;
    logic [PW-1:0] w_wr_nxt;
    logic [PW-1:0] w_rd_nxt;

    assign w_wr_en  = w_push_ok && (push_src == 2'(n)) && (push_len != 8'd0);
    assign w_pop[n] = (r_state == S_IDLE) && !r_empty && processor_ready[n];
    assign w_full[n] = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_wr_nxt = r_wr_ptr + PW'(w_wr_en);
    assign w_rd_nxt = r_rd_ptr + PW'(w_pop[n]);

    // Storage is not reset; validity is carried by the pointers.
    always_ff @(posedge clock) begin
      if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= {push_len, push_dst};
    end

    // Empty is computed from the next pointers so the registered flag is exact.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_empty  <= 1'b1;
      end else begin
        r_wr_ptr <= w_wr_nxt;
        r_rd_ptr <= w_rd_nxt;
        r_empty  <= (w_wr_nxt == w_rd_nxt);
      end
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
    end

    // The timer is cleared while in ISSUE, so matching ACK_TIMEOUT-1 in
    // WAIT_ACK gives a re-pulse period of ACK_TIMEOUT+1 cycles.
    always_comb begin
      w_state_nxt = r_state;
      case (r_state)
        S_IDLE:      if (w_pop[n]) w_state_nxt = S_ISSUE;
        S_ISSUE:     w_state_nxt = S_WAIT_ACK;
        S_WAIT_ACK: begin
          if (!processor_ready[n])                    w_state_nxt = S_WAIT_DONE;
          else if (r_timer == TW'(ACK_TIMEOUT - 1))   w_state_nxt = S_ISSUE;
        end
        S_WAIT_DONE: if (processor_ready[n]) w_state_nxt = S_IDLE;
        default:     w_state_nxt = S_IDLE;
      endcase
    end

    // Head word is latched on the pop edge and held until the next pop.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        r_len   <= '0;
        r_dst   <= '0;
        r_timer <= '0;
      end else begin
        if (w_pop[n]) {r_len, r_dst} <= r_mem[r_rd_ptr[AW-1:0]];
        if (r_state == S_ISSUE)         r_timer <= '0;
        else if (r_state == S_WAIT_ACK) r_timer <= r_timer + 1'b1;
      end
    end

    assign w_cfg[n]      = {r_len, r_dst, (r_state == S_ISSUE)};
    assign busy[n]       = (r_state != S_IDLE);
    assign fifo_empty[n] = r_empty;

`ifdef NOC_SCHED_STATS_EN
    logic [15:0] r_done_cnt;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        r_done_cnt <= '0;
      end else if ((r_state == S_WAIT_DONE) && processor_ready[n] &&
                   (r_done_cnt != 16'hFFFF)) begin
        r_done_cnt <= r_done_cnt + 16'd1;
      end
    end

    assign done_count[16*n +: 16] = r_done_cnt;
`endif
  end

  assign p0_configure = w_cfg[0];
  assign p1_configure = w_cfg[1];
  assign p2_configure = w_cfg[2];
  assign p3_configure = w_cfg[3];

endmodule

// File: tb/tb_noc_request_scheduler.sv
// ---------------------------------------------------------------------------
// tb_noc_request_scheduler
//   Scoreboard bench: every accepted push queues its expected configure word
//   per source; the negedge monitor pops and compares on each req pulse.
//   Re-pulses (ready never dropped) are compared against the last word and
//   the expected period. A small responder per source can emulate the
//   processor by dropping ready for a few cycles after each req pulse.
// ---------------------------------------------------------------------------
module tb_noc_request_scheduler;

  localparam int DEPTH       = 4;
  localparam int ACK_TIMEOUT = 15;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        push_valid = 1'b0;
  logic [1:0]  push_src = 2'd0;
  logic [1:0]  push_dst = 2'd0;
  logic [7:0]  push_len = 8'd0;
  logic        push_ready;
  logic [3:0]  processor_ready;
  logic [10:0] p0_configure, p1_configure, p2_configure, p3_configure;
  logic [3:0]  busy;
  logic [3:0]  fifo_empty;
  logic        err_zero_len;
`ifdef NOC_SCHED_STATS_EN
  logic [63:0] done_count;
`endif

  logic [3:0]  man_ready = 4'hF;
  logic [3:0]  ack_low   = 4'h0;
  logic [3:0]  auto_ack  = 4'h0;
  int          ack_cnt [4];
  assign processor_ready = man_ready & ~ack_low;

  logic [10:0] cfg [4];
  assign cfg[0] = p0_configure;
  assign cfg[1] = p1_configure;
  assign cfg[2] = p2_configure;
  assign cfg[3] = p3_configure;

  logic [10:0] sbq [4][$];
  logic [10:0] last_word [4];
  int          last_cyc [4];
  int          pulses [4];
  bit          pend [4];
  int          cyc = 0;
  int          n_total = 0;
  int          n_bad = 0;
  int          exp_done0 = 0;

  noc_request_scheduler #(.DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .push_valid(push_valid), .push_src(push_src), .push_dst(push_dst),
    .push_len(push_len), .push_ready(push_ready),
    .processor_ready(processor_ready),
    .p0_configure(p0_configure), .p1_configure(p1_configure),
    .p2_configure(p2_configure), .p3_configure(p3_configure),
    .busy(busy), .fifo_empty(fifo_empty), .err_zero_len(err_zero_len)
`ifdef NOC_SCHED_STATS_EN
    , .done_count(done_count)
`endif
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [1:0] s, input logic [1:0] d, input logic [7:0] l,
                      input bit acc);
    push_valid = 1'b1;
    push_src   = s;
    push_dst   = d;
    push_len   = l;
    if (acc) begin
      sbq[s].push_back({l, d, 1'b1});
      if (s == 2'd0) exp_done0++;
    end
    @(posedge clock);
    #1;
    push_valid = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    int left;
    left = 0;
    for (int i = 0; i < max_cyc; i++) begin
      left = sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size();
      if (left == 0 && busy == 4'h0) break;
      step(1);
    end
    left = sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size();
    chk("drain_left", 64'(left), 64'd0);
    chk("drain_busy", 64'(busy), 64'd0);
  endtask

  // Monitor/scoreboard and processor responder.
  always @(negedge clock) begin
    for (int n = 0; n < 4; n++) begin
      if (cfg[n][0]) begin
        if (pend[n]) begin
          chk("repulse_word", 64'(cfg[n]), 64'(last_word[n]));
          chk("repulse_period", 64'(cyc - last_cyc[n]), 64'(ACK_TIMEOUT + 1));
        end else if (sbq[n].size() == 0) begin
          chk("unexpected_issue", 64'(cfg[n]), 64'd0);
        end else begin
          last_word[n] = sbq[n].pop_front();
          chk("issue_word", 64'(cfg[n]), 64'(last_word[n]));
        end
        pend[n]     = 1'b1;
        last_cyc[n] = cyc;
        pulses[n]++;
      end else if (!processor_ready[n]) begin
        pend[n] = 1'b0;
      end
      if (ack_cnt[n] != 0)               ack_cnt[n]--;
      else if (auto_ack[n] && cfg[n][0]) ack_cnt[n] = 4;
      ack_low[n] = (ack_cnt[n] != 0);
    end
  end

  initial begin
    int p3_before;

    // Power-on reset
    step(3);
    chk("rst_cfg", {p3_configure, p2_configure, p1_configure, p0_configure}, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_empty", 64'(fifo_empty), 64'hF);
    chk("rst_err", 64'(err_zero_len), 64'd0);
    reset = 1'b1;
    step(2);
    chk("idle_push_ready", 64'(push_ready), 64'd1);

    // Single transfer src0 -> dst3, len 8, manual ready handshake
    push(2'd0, 2'd3, 8'd8, 1'b1);
    chk("t2_empty0_after_push", 64'(fifo_empty[0]), 64'd0);
    chk("t2_cfg_before_issue", 64'(p0_configure), 64'd0);
    step(1);
    chk("t2_cfg_req", 64'(p0_configure), 64'h047);
    chk("t2_busy_issue", 64'(busy[0]), 64'd1);
    step(1);
    chk("t2_cfg_wait", 64'(p0_configure), 64'h046);
    man_ready[0] = 1'b0;
    step(1);
    chk("t2_busy_done", 64'(busy[0]), 64'd1);
    step(4);
    chk("t2_busy_hold", 64'(busy[0]), 64'd1);
    chk("t2_cfg_hold", 64'(p0_configure), 64'h046);
    man_ready[0] = 1'b1;
    step(1);
    chk("t2_busy_clear", 64'(busy[0]), 64'd0);
    chk("t2_cfg_after", 64'(p0_configure), 64'h046);
    chk("t2_pulses", 64'(pulses[0]), 64'd1);

    // Zero-length push on src1
    push(2'd1, 2'd2, 8'd0, 1'b0);
    chk("t4_err_pulse", 64'(err_zero_len), 64'd1);
    chk("t4_empty1", 64'(fifo_empty[1]), 64'd1);
    step(1);
    chk("t4_err_clear", 64'(err_zero_len), 64'd0);
    step(2);
    chk("t4_cfg1", 64'(p1_configure), 64'd0);
    chk("t4_busy1", 64'(busy[1]), 64'd0);

    // Fill src2, overflow push dropped, drain in order
    man_ready[2] = 1'b0;
    auto_ack[2]  = 1'b1;
    for (int i = 0; i < DEPTH; i++) push(2'd2, 2'(i), 8'(i + 1), 1'b1);
    push_src = 2'd2;
    #1;
    chk("t3_full_ready", 64'(push_ready), 64'd0);
    push_src = 2'd0;
    #1;
    chk("t3_other_ready", 64'(push_ready), 64'd1);
    push(2'd2, 2'd1, 8'h55, 1'b0);
    chk("t3_no_err", 64'(err_zero_len), 64'd0);
    chk("t3_empty2", 64'(fifo_empty[2]), 64'd0);
    man_ready[2] = 1'b1;
    drain(200);
    chk("t3_pulses", 64'(pulses[2]), 64'(DEPTH));
    chk("t3_empty_after", 64'(fifo_empty[2]), 64'd1);

    // Ready3 held high: periodic re-pulse with the same word
    p3_before = pulses[3];
    push(2'd3, 2'd1, 8'd5, 1'b1);
    step(40);
    man_ready[3] = 1'b0;
    step(2);
    man_ready[3] = 1'b1;
    step(3);
    chk("t5_busy3", 64'(busy[3]), 64'd0);
    chk("t5_pulses", 64'(pulses[3] - p3_before), 64'd3);
    chk("t5_cfg3", 64'(p3_configure), 64'h02A);

    // Simultaneous pops on all sources with a push into full src0
    man_ready = 4'h0;
    for (int i = 0; i < DEPTH; i++) push(2'd0, 2'd1, 8'(8'h10 + i), 1'b1);
    push(2'd1, 2'd1, 8'd7,   1'b1);
    push(2'd2, 2'd0, 8'd9,   1'b1);
    push(2'd3, 2'd2, 8'hFF,  1'b1);
    chk("t6_preload_empty", 64'(fifo_empty), 64'h0);
    auto_ack  = 4'hF;
    man_ready = 4'hF;
    push(2'd0, 2'd3, 8'h20, 1'b1);
    chk("t6_all_busy", 64'(busy), 64'hF);
    chk("t6_all_req", 64'({p3_configure[0], p2_configure[0], p1_configure[0], p0_configure[0]}), 64'hF);
    chk("t6_empty", 64'(fifo_empty), 64'hE);
    chk("t6_src0_full", 64'(push_ready), 64'd0);
    drain(400);
    chk("t6_empty_end", 64'(fifo_empty), 64'hF);
`ifdef NOC_SCHED_STATS_EN
    chk("stats_done0", 64'(done_count[15:0]), 64'(exp_done0));
`endif

    // Reset asserted mid-WAIT_DONE with three entries queued
    auto_ack     = 4'h0;
    man_ready[1] = 1'b0;
    for (int i = 0; i < DEPTH; i++) push(2'd1, 2'd3, 8'(8'h30 + i), 1'b1);
    man_ready[1] = 1'b1;
    step(1);
    man_ready[1] = 1'b0;
    step(2);
    chk("t1_busy_pre", 64'(busy[1]), 64'd1);
    chk("t1_queued", 64'(fifo_empty[1]), 64'd0);
    reset = 1'b0;
    sbq[1].delete();
    #1;
    chk("t1_rst_cfg", {p3_configure, p2_configure, p1_configure, p0_configure}, 64'd0);
    chk("t1_rst_busy", 64'(busy), 64'd0);
    chk("t1_rst_empty", 64'(fifo_empty), 64'hF);
    step(2);
    chk("t1_rst_hold_busy", 64'(busy), 64'd0);
    man_ready = 4'hF;
    reset = 1'b1;
    step(4);
    chk("t1_post_cfg", {p3_configure, p2_configure, p1_configure, p0_configure}, 64'd0);
    chk("t1_post_busy", 64'(busy), 64'd0);
    chk("t1_post_empty", 64'(fifo_empty), 64'hF);
    chk("t1_post_err", 64'(err_zero_len), 64'd0);
`ifdef NOC_SCHED_STATS_EN
    chk("stats_after_reset", done_count, 64'd0);
`endif
    chk("sb_leftover", 64'(sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
